// File: rtl/pwm_8bit.sv
// Free-running PWM with a shadowed duty register that is committed only at the
// period wrap, so each period is generated from a single, stable duty value.
module pwm_8bit #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] value_input,
  output logic             out
);

  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             out_q, out_d;

  generate
    if (PRESCALE > 1) begin : g_tick
      localparam int TW = $clog2(PRESCALE);
      logic [TW-1:0] tick_q, tick_d;

      assign step   = (tick_q == TW'(PRESCALE - 1));
      assign tick_d = step ? '0 : tick_q + TW'(1);

      always_ff @(posedge clk) begin
        if (rst) tick_q <= '0;
        else     tick_q <= tick_d;
      end
    end else begin : g_no_tick
      assign step = 1'b1;
    end
  endgenerate

  // A write on the wrap edge itself flows through shadow_d straight into duty.
  always_comb begin
    boundary = step && (cnt_q == {WIDTH{1'b1}});
    cnt_d    = step ? cnt_q + WIDTH'(1) : cnt_q;
    shadow_d = en ? value_input : shadow_q;
    duty_d   = boundary ? shadow_d : duty_q;
    out_d    = (cnt_d < duty_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      duty_q   <= '0;
      out_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      duty_q   <= duty_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_8bit.sv
// Directed checks for pwm_8bit: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_pwm_8bit;

  logic       clk;
  logic       rst1, en1, out1;
  logic [7:0] val1;
  logic       rst4, en4, out4;
  logic [7:0] val4;

  int   checks;
  int   failures;
  logic [7:0] m_cnt;
  int   highs;
  int   total;

  pwm_8bit #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .value_input(val1), .out(out1)
  );

  pwm_8bit #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .value_input(val4), .out(out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it. m_cnt tracks dut1's counter.
  task automatic tick();
    @(posedge clk);
    #1;
    m_cnt = m_cnt + 8'd1;
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    en1  = 1'b1;
    val1 = value;
    tick();
    en1  = 1'b0;
  endtask

  task automatic waitCnt(input logic [7:0] target);
    for (int i = 0; i < 256 && m_cnt != target; i++) tick();
  endtask

  // Counts dut1 high cycles over one full period starting at cnt=0; ends at the next boundary.
  task automatic runPeriod(output int high_count);
    high_count = 0;
    for (int i = 0; i < 256; i++) begin
      if (out1 === 1'b1) high_count++;
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_cnt    = 8'd0;
    rst1 = 1'b1; en1 = 1'b1; val1 = 8'hFF;
    rst4 = 1'b1; en4 = 1'b0; val4 = 8'd0;

    for (int i = 0; i < 3; i++) tick();
    m_cnt = 8'd0;
    checkOutput("reset_out", out1, 0);
    rst1 = 1'b0; en1 = 1'b0; val1 = 8'd0;

    runPeriod(highs);
    checkOutput("first_period_discarded_write", highs, 0);

    applyStimulus(8'd128);
    waitCnt(8'd0);
    checkOutput("duty128_starts_high", out1, 1);
    runPeriod(highs);
    checkOutput("duty128_period_a", highs, 128);
    runPeriod(highs);
    checkOutput("duty128_period_b", highs, 128);

    applyStimulus(8'd0);
    waitCnt(8'd0);
    total = 0;
    for (int p = 0; p < 3; p++) begin
      runPeriod(highs);
      total += highs;
    end
    checkOutput("duty0_three_periods", total, 0);

    applyStimulus(8'd255);
    waitCnt(8'd255);
    tick();
    runPeriod(highs);
    checkOutput("duty255_period", highs, 255);
    waitCnt(8'd255);
    checkOutput("duty255_low_at_top", out1, 0);
    tick();

    applyStimulus(8'd1);
    waitCnt(8'd0);
    runPeriod(highs);
    checkOutput("duty1_period", highs, 1);

    applyStimulus(8'd64);
    waitCnt(8'd0);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      if (out1 === 1'b1) highs++;
      en1 = (m_cnt == 8'd10) || (m_cnt == 8'd100);
      val1 = (m_cnt == 8'd10) ? 8'd200 : 8'd32;
      tick();
    end
    en1 = 1'b0;
    checkOutput("deferred_current_period", highs, 64);
    runPeriod(highs);
    checkOutput("deferred_next_period", highs, 32);

    waitCnt(8'd255);
    applyStimulus(8'd10);
    checkOutput("collision_immediate", out1, 1);
    runPeriod(highs);
    checkOutput("collision_period", highs, 10);

    // PRESCALE=4 instance: steps every 4 clocks, period 1024 clocks.
    tick();
    rst4 = 1'b0; en4 = 1'b1; val4 = 8'd3;
    tick();
    en4 = 1'b0;
    for (int i = 0; i < 1023; i++) tick();
    highs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (out4 === 1'b1) highs++;
      tick();
    end
    checkOutput("p4_high_time", highs, 12);

    for (int i = 0; i < 4; i++) tick();
    checkOutput("p4_cnt1_high", out4, 1);
    rst4 = 1'b1; en4 = 1'b1; val4 = 8'd200;
    tick();
    checkOutput("p4_mid_reset_out", out4, 0);
    rst4 = 1'b0; en4 = 1'b1; val4 = 8'd3;
    tick();
    en4 = 1'b0;
    highs = (out4 === 1'b1) ? 1 : 0;
    for (int i = 0; i < 1022; i++) begin
      tick();
      if (out4 === 1'b1) highs++;
    end
    checkOutput("p4_post_reset_duty0", highs, 0);
    tick();
    checkOutput("p4_restart_boundary", out4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
